// File: rtl/maze_tracker.sv
// Pac-Man grid tracker: position, pellet map, score, ghost collision and win/loose status.
// Build option: define TUNNEL_EN for horizontal wrap-around at the left/right maze edges.
module maze_tracker #(
    parameter int                   COLS    = 8,
    parameter int                   ROWS    = 8,
    parameter int                   START_X = 1,
    parameter int                   START_Y = 1,
    parameter logic [ROWS*COLS-1:0] WALLS   = 64'hFF81_8181_8181_81FF,
    localparam int                  XW      = $clog2(COLS),
    localparam int                  YW      = $clog2(ROWS),
    localparam int                  PW      = $clog2(ROWS*COLS+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m_up,
    input  logic          m_down,
    input  logic          m_right,
    input  logic          m_left,
    input  logic          m_hold,
    input  logic          e_start,
    input  logic [XW-1:0] ghost_x,
    input  logic [YW-1:0] ghost_y,
    output logic          uE,
    output logic          dE,
    output logic          rE,
    output logic          lE,
    output logic          win,
    output logic          loose,
    output logic [XW-1:0] pac_x,
    output logic [YW-1:0] pac_y,
    output logic [PW-1:0] pellets_left,
    output logic [PW-1:0] score
);

    localparam int NC = ROWS * COLS;
    localparam logic [NC-1:0] INIT_MAP  = ~WALLS & ~(NC'(1) << (START_Y * COLS + START_X));
    localparam logic [PW-1:0] INIT_LEFT = PW'($countones(INIT_MAP));

    function automatic logic wall_at(input int x, input int y);
        logic [NC-1:0] sh;
        sh = WALLS >> (y * COLS + x);
        return sh[0];
    endfunction

    logic [XW-1:0] pac_x_reg;
    logic [YW-1:0] pac_y_reg;
    logic [NC-1:0] pellet_reg;
    logic [PW-1:0] left_reg;
    logic [PW-1:0] score_reg;
    logic          win_reg;
    logic          loose_reg;

    logic          up_en, down_en, right_en, left_en;
    logic          move_go, eat, collide, win_next;
    int            cx, cy, dest_x, dest_y, dest_idx;
    logic [NC-1:0] pel_sh;
    logic [NC-1:0] clear_vec;

    always_comb begin
        cx      = int'(pac_x_reg);
        cy      = int'(pac_y_reg);
        up_en   = (cy > 0) && !wall_at(cx, cy - 1);
        down_en = (cy < ROWS - 1) && !wall_at(cx, cy + 1);
`ifdef TUNNEL_EN
        left_en  = (cx > 0) ? !wall_at(cx - 1, cy) : !wall_at(COLS - 1, cy);
        right_en = (cx < COLS - 1) ? !wall_at(cx + 1, cy) : !wall_at(0, cy);
`else
        left_en  = (cx > 0) && !wall_at(cx - 1, cy);
        right_en = (cx < COLS - 1) && !wall_at(cx + 1, cy);
`endif
    end

    // Highest-priority strobe picks the direction; its enable alone decides the move.
    always_comb begin
        move_go = 1'b0;
        dest_x  = cx;
        dest_y  = cy;
        if (!win_reg && !loose_reg && !m_hold) begin
            if (m_up) begin
                move_go = up_en;
                dest_y  = cy - 1;
            end else if (m_down) begin
                move_go = down_en;
                dest_y  = cy + 1;
            end else if (m_right) begin
                move_go = right_en;
                dest_x  = (cx == COLS - 1) ? 0 : cx + 1;
            end else if (m_left) begin
                move_go = left_en;
                dest_x  = (cx == 0) ? COLS - 1 : cx - 1;
            end
        end
        dest_idx = dest_y * COLS + dest_x;
        pel_sh   = pellet_reg >> dest_idx;
        eat      = move_go && pel_sh[0];
        collide  = (pac_x_reg == ghost_x) && (pac_y_reg == ghost_y);
        win_next = (left_reg == '0) && !collide && !loose_reg;
    end

    for (genvar gi = 0; gi < NC; gi++) begin : g_cell
        assign clear_vec[gi] = eat && (dest_idx == gi);
    end

    always_ff @(posedge clk) begin
        if (reset || e_start) begin
            pac_x_reg  <= XW'(START_X);
            pac_y_reg  <= YW'(START_Y);
            pellet_reg <= INIT_MAP;
            left_reg   <= INIT_LEFT;
            score_reg  <= '0;
            win_reg    <= 1'b0;
            loose_reg  <= 1'b0;
        end else begin
            if (move_go) begin
                pac_x_reg <= XW'(dest_x);
                pac_y_reg <= YW'(dest_y);
            end
            if (eat) begin
                left_reg  <= left_reg - PW'(1);
                score_reg <= score_reg + PW'(1);
            end
            pellet_reg <= pellet_reg & ~clear_vec;
            if (collide)
                loose_reg <= 1'b1;
            if (win_next)
                win_reg <= 1'b1;
        end
    end

    assign uE           = up_en;
    assign dE           = down_en;
    assign rE           = right_en;
    assign lE           = left_en;
    assign win          = win_reg;
    assign loose        = loose_reg;
    assign pac_x        = pac_x_reg;
    assign pac_y        = pac_y_reg;
    assign pellets_left = left_reg;
    assign score        = score_reg;

endmodule

// File: tb/tb_maze_tracker.sv
// Directed and random-walk bench for maze_tracker with a grid-level reference model.
module tb_maze_tracker;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    // Border walls, gaps at (0,3) and (7,3), interior wall at (3,4).
    localparam logic [63:0] MAP = 64'hFF81_8189_0081_81FF;

    logic       clk = 1'b0;
    logic       reset, m_up, m_down, m_right, m_left, m_hold, e_start;
    logic [2:0] ghost_x, ghost_y;
    logic       uE, dE, rE, lE, win, loose;
    logic [2:0] pac_x, pac_y;
    logic [6:0] pellets_left, score;

    always #5 clk = ~clk;

    maze_tracker #(
        .COLS(COLS), .ROWS(ROWS), .START_X(1), .START_Y(1), .WALLS(MAP)
    ) dut (
        .clk(clk), .reset(reset),
        .m_up(m_up), .m_down(m_down), .m_right(m_right), .m_left(m_left),
        .m_hold(m_hold), .e_start(e_start),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .uE(uE), .dE(dE), .rE(rE), .lE(lE),
        .win(win), .loose(loose),
        .pac_x(pac_x), .pac_y(pac_y),
        .pellets_left(pellets_left), .score(score)
    );

    // Reference model state
    bit   mwall [ROWS][COLS];
    bit   mpel  [ROWS][COLS];
    int   mx, my, mscore, mleft;
    bit   mwin, mloose;
    int   DXS [4] = '{0, 0, 1, -1};
    int   DYS [4] = '{-1, 1, 0, 0};
    int   checks = 0;
    int   fails  = 0;
    logic [63:0] mapv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_en(input int d);
        int tx, ty;
        tx = mx + DXS[d];
        ty = my + DYS[d];
        if (ty < 0 || ty >= ROWS) return 1'b0;
        if (tx < 0 || tx >= COLS) begin
`ifdef TUNNEL_EN
            tx = (tx + COLS) % COLS;
`else
            return 1'b0;
`endif
        end
        return !mwall[ty][tx];
    endfunction

    task automatic model_reset();
        mleft = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                mwall[y][x] = mapv[y*COLS + x];
                mpel[y][x]  = !mwall[y][x] && !(x == 1 && y == 1);
                if (mpel[y][x]) mleft++;
            end
        mx = 1; my = 1; mscore = 0; mwin = 0; mloose = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pac_x"}, 32'(pac_x), mx);
        chk({tag, ".pac_y"}, 32'(pac_y), my);
        chk({tag, ".score"}, 32'(score), mscore);
        chk({tag, ".left"},  32'(pellets_left), mleft);
        chk({tag, ".win"},   32'(win), 32'(mwin));
        chk({tag, ".loose"}, 32'(loose), 32'(mloose));
        chk({tag, ".uE"},    32'(uE), 32'(model_en(0)));
        chk({tag, ".dE"},    32'(dE), 32'(model_en(1)));
        chk({tag, ".rE"},    32'(rE), 32'(model_en(2)));
        chk({tag, ".lE"},    32'(lE), 32'(model_en(3)));
    endtask

    // dirs = {left, right, down, up}
    task automatic step(input string tag, input bit [3:0] dirs, input bit hold,
                        input bit st, input bit rst, input int gx, input int gy);
        bit coin, wset;
        int d;
        @(negedge clk);
        {m_left, m_right, m_down, m_up} = dirs;
        m_hold  = hold;
        e_start = st;
        reset   = rst;
        ghost_x = 3'(gx);
        ghost_y = 3'(gy);
        @(posedge clk);
        if (rst || st) begin
            model_reset();
        end else begin
            coin = (mx == gx) && (my == gy);
            wset = (mleft == 0) && !coin && !mloose;
            if (!mwin && !mloose && !hold && dirs != 4'b0) begin
                d = 0;
                while (!dirs[d]) d++;
                if (model_en(d)) begin
                    mx = (mx + DXS[d] + COLS) % COLS;
                    my = my + DYS[d];
                    if (mpel[my][mx]) begin
                        mpel[my][mx] = 0;
                        mleft--;
                        mscore++;
                    end
                end
            end
            if (coin) mloose = 1;
            if (wset) mwin = 1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int steps;
        int init_left;
        int opts[$];
        bit [3:0] dirs;
        int r;

        mapv = MAP;
        {reset, m_up, m_down, m_right, m_left, m_hold, e_start} = 7'b1000000;
        ghost_x = 3'd0;
        ghost_y = 3'd0;

        // Reset state
        step("reset", 4'b0000, 0, 0, 1, 0, 0);
        step("reset", 4'b0000, 0, 0, 1, 0, 0);
        init_left = mleft;
        chk("rst.pac_x", 32'(pac_x), 1);
        chk("rst.pac_y", 32'(pac_y), 1);
        chk("rst.uE", 32'(uE), 0);
        chk("rst.lE", 32'(lE), 0);
        chk("rst.rE", 32'(rE), 1);
        chk("rst.dE", 32'(dE), 1);
        chk("rst.left", 32'(pellets_left), 36);
        step("idle", 4'b0000, 0, 0, 0, 0, 0);

        // Three right pulses then one left
        for (int i = 0; i < 3; i++) begin
            step("right", 4'b0100, 0, 0, 0, 0, 0);
            step("idle", 4'b0000, 0, 0, 0, 0, 0);
        end
        chk("r3.pac_x", 32'(pac_x), 4);
        chk("r3.score", 32'(score), 3);
        chk("r3.left", 32'(pellets_left), 32'(init_left - 3));
        step("left", 4'b1000, 0, 0, 0, 0, 0);
        chk("l1.pac_x", 32'(pac_x), 3);
        chk("l1.score", 32'(score), 3);

        // Blocked up, then up+left: up wins and is blocked
        step("up_blk", 4'b0001, 0, 0, 0, 0, 0);
        chk("upblk.pac_y", 32'(pac_y), 1);
        step("up_left", 4'b1001, 0, 0, 0, 0, 0);
        chk("upleft.pac_x", 32'(pac_x), 3);
        step("hold", 4'b0100, 1, 0, 0, 0, 0);
        chk("hold.pac_x", 32'(pac_x), 3);

        // Ghost collision
        step("reset", 4'b0000, 0, 0, 1, 0, 0);
        step("g_right", 4'b0100, 0, 0, 0, 2, 1);
        chk("g.pac_x", 32'(pac_x), 2);
        chk("g.loose_lag", 32'(loose), 0);
        step("g_idle", 4'b0000, 0, 0, 0, 2, 1);
        chk("g.loose", 32'(loose), 1);
        step("g_frozen", 4'b0100, 0, 0, 0, 2, 1);
        chk("g.frozen_x", 32'(pac_x), 2);
        step("estart", 4'b0000, 0, 1, 0, 2, 1);
        chk("es.loose", 32'(loose), 0);
        chk("es.pac_x", 32'(pac_x), 1);

        // Edge behaviour at (0,3)
        step("down", 4'b0010, 0, 0, 0, 0, 0);
        step("down", 4'b0010, 0, 0, 0, 0, 0);
        step("left", 4'b1000, 0, 0, 0, 0, 0);
        chk("edge.pac_x", 32'(pac_x), 0);
        chk("edge.pac_y", 32'(pac_y), 3);
        step("edge_left", 4'b1000, 0, 0, 0, 0, 0);
`ifdef TUNNEL_EN
        chk("tunnel.pac_x", 32'(pac_x), 7);
`else
        chk("wall.pac_x", 32'(pac_x), 0);
`endif

        // Random walk until every pellet is eaten
        step("estart", 4'b0000, 0, 1, 0, 0, 0);
        steps = 0;
        while (mleft > 0 && steps < 20000) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                opts.delete();
                for (int d = 0; d < 4; d++)
                    if (model_en(d)) opts.push_back(d);
                dirs = 4'b0;
                dirs[opts[$urandom_range(0, opts.size() - 1)]] = 1'b1;
                step("walk", dirs, 0, 0, 0, 0, 0);
            end else begin
                step("walk_rnd", 4'($urandom_range(0, 15)), r == 9, 0, 0, 0, 0);
            end
            steps++;
        end
        chk("walk.within_budget", 32'(steps < 20000), 1);
        chk("win.lag", 32'(win), 0);
        step("win_idle", 4'b0000, 0, 0, 0, 0, 0);
        chk("win.set", 32'(win), 1);
        for (int i = 0; i < 6; i++)
            step("win_hold", 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0);
        chk("win.sticky", 32'(win), 1);
        step("estart", 4'b0000, 0, 1, 0, 0, 0);
        chk("win.clear", 32'(win), 0);
        chk("win.reload", 32'(pellets_left), 32'(init_left));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
